fetch_align_buffer: RTL and testbench
=====================================

// Module: fetch_align_buffer
// PURPOSE
//  Instruction prefetch/alignment stage sitting upstream of the decompression unit and the IF/ID register.
//  Fetches 32-bit aligned words from instruction memory into a halfword queue.
//  Presents one complete instruction per handshake: a 16-bit compressed one, or a 32-bit one that may straddle a word boundary.
//  Flushes and refetches on a redirect (taken branch, jal or jalr) from the MEM stage.
// PARAMETERS
//  XLEN      32     address/data width
//  DEPTH_HW  4      halfword queue depth; power of 2, >= 4
//  RESET_PC  32'h0  first fetch PC after reset; bit 0 ignored
// PORTS
//  clk              in   1     clock
//  reset            in   1     asynchronous, active-high
//  redirect_valid   in   1     load new PC, flush queue
//  redirect_pc      in   XLEN  target PC; bit 0 treated as 0
//  mem_req_valid    out  1     word fetch request
//  mem_req_addr     out  XLEN  word address, [1:0]=2'b00
//  mem_req_ready    in   1     memory accepts request
//  mem_resp_valid   in   1     fetched word returned
//  mem_resp_data    in   32    fetched word, little-endian
//  inst_valid       out  1     inst_data complete
//  inst_ready       in   1     downstream consumes inst
//  inst_data        out  32    {h1,h0} for 32-bit; {16'h0,h0} for compressed
//  inst_pc          out  XLEN  PC of inst_data
//  inst_compressed  out  1     h0[1:0]!=2'b11
// BEHAVIOUR
//  Reset: queue empty; outstanding=0; drop=0; inst_valid=0; mem_req_valid=0.
//   inst_pc=RESET_PC; fetch_addr={RESET_PC[31:2],2'b00}; skip_low=RESET_PC[1].
//  Request: mem_req_valid = !outstanding & !redirect_valid & (DEPTH_HW-count >= 2).
//   Once raised, mem_req_addr is held until accepted; only a redirect may withdraw it.
//   On valid&ready: outstanding=1, fetch_addr+=4.
//   At most one request outstanding. Response arrives no earlier than the cycle after acceptance.
//  Response: clears outstanding.
//   If drop=1: data discarded, drop=0.
//   Else if skip_low: push data[31:16] only, skip_low=0.
//   Else: push data[15:0] then data[31:16].
//  Output (combinational from queue head h0, next h1):
//   Compressed (h0[1:0]!=2'b11): inst_valid = count>=1; pop 1; inst_pc+=2.
//   Otherwise: inst_valid = count>=2; pop 2; inst_pc+=4.
//   Latency: response in cycle t -> inst_valid in cycle t+1 (registered queue).
//  Push and pop in the same cycle are legal. The count never exceeds DEPTH_HW.
//   The queue pointers wrap modulo DEPTH_HW.
//   fetch_addr wraps modulo 2^XLEN.
//  Redirect (highest priority; same-cycle pop and push are ignored):
//   Queue cleared; inst_pc={redirect_pc[31:1],1'b0}; fetch_addr={redirect_pc[31:2],2'b00}; skip_low=redirect_pc[1].
//   inst_valid=0 in the redirect cycle.
//   If outstanding & !mem_resp_valid: drop=1, so the stale response is discarded.
//   If mem_resp_valid in the same cycle: that response is discarded, outstanding=0, drop stays 0.
//   Back-to-back redirects: the last one wins; drop stays set until one stale response is discarded.
//  Reset mid-operation: immediate return to reset state.
//   A memory response arriving after reset deasserts is discarded only if memory also resets.
//   Memory sharing the same reset is required.
// STRUCTURE
//  Shared defines header: macro for the compressed test (inst[1:0]!=2'b11) and the RESET_PC default.
//  Sub-module fab_hw_queue: halfword FIFO, DEPTH_HW x 16.
//   Ports: push of 0/1/2 halfwords, pop of 0/1/2, flush, count, and head h0/h1 peek.
//  Top level: fetch_addr/outstanding/drop/skip_low control and inst_pc tracking.
// TESTING
//  1 Sequential 32-bit stream, RESET_PC=0, words 0x00500093, 0x00a00113.
//    -> inst 0x00500093 @pc 0, then 0x00a00113 @pc 4; inst_compressed=0.
//  2 Mixed stream, word 0x4505_0505: h0=0x0505 (c.addi), h1=0x4505 (c.li).
//    -> two compressed insts, pc 0 and 2, inst_data 0x00000505, 0x00004505.
//  3 Straddling: word0=0x0093_0505, word1=0x????_0050.
//    -> inst0 0x0505 @pc0 (compressed); inst1 0x00500093 @pc2, valid only after word1 arrives.
//  4 Redirect to 0x102 while a request is outstanding.
//    -> stale response dropped; next req addr 0x100; low half skipped; first inst_pc=0x102.
//  5 Backpressure: inst_ready=0 for 10 cycles.
//    -> queue fills to DEPTH_HW; mem_req_valid=0 while free<2; no data lost; order preserved on release.
//  6 Redirect and mem_resp_valid in the same cycle, then reset asserted mid-fetch.
//    -> response discarded, no drop pending; after reset inst_valid=0 and req addr=RESET_PC.

Source files
------------

// File: rtl/fetch_align_buffer_pkg.sv
// Shared definitions for the fetch/align buffer slice.
//   - Default parameter values (address width, queue depth, reset PC).
//   - is_compressed(): a halfword starts a 16-bit instruction unless its
//     two low bits are 2'b11.
package fetch_align_buffer_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned DEPTH_HW_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

    function automatic logic is_compressed(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fab_hw_queue.sv
// fab_hw_queue: halfword FIFO, DEPTH_HW entries of 16 bits.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           empty the queue (overrides push and pop)
//   push_cnt        0/1/2 halfwords to append (push_hw0 first, then push_hw1)
//   pop_cnt         0/1/2 halfwords to remove from the head
//   count           current occupancy, 0..DEPTH_HW
//   h0, h1          head halfword and the one behind it (combinational peek)
// The caller guarantees count + push - pop never exceeds DEPTH_HW and that it
// never pops more than it holds. Pointers wrap naturally because DEPTH_HW is
// a power of two.
module fab_hw_queue
    import fetch_align_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_HW = DEPTH_HW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [1:0]                 push_cnt,
    input  logic [15:0]                push_hw0,
    input  logic [15:0]                push_hw1,
    input  logic [1:0]                 pop_cnt,
    output logic [$clog2(DEPTH_HW):0]  count,
    output logic [15:0]                h0,
    output logic [15:0]                h1
);

    localparam int unsigned AW = $clog2(DEPTH_HW);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_p1;
    logic [AW-1:0] rd_ptr_p1;
    logic [DEPTH_HW-1:0][15:0] slots;

    assign wr_ptr_p1 = wr_ptr_q + AW'(1);
    assign rd_ptr_p1 = rd_ptr_q + AW'(1);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop_cnt);
            wr_ptr_d = wr_ptr_q + AW'(push_cnt);
            count_d  = count_q + (AW+1)'(push_cnt) - (AW+1)'(pop_cnt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // One register per slot. A full queue may be popped and refilled in the
    // same cycle: the head is read from the old contents, so writing the
    // slots being vacated is safe.
    generate
        for (genvar gi = 0; gi < DEPTH_HW; gi++) begin : g_slot
            logic [15:0] slot_q, slot_d;

            always_comb begin
                slot_d = slot_q;
                if (!flush) begin
                    if (push_cnt != 2'd0 && wr_ptr_q == AW'(gi)) begin
                        slot_d = push_hw0;
                    end else if (push_cnt == 2'd2 && wr_ptr_p1 == AW'(gi)) begin
                        slot_d = push_hw1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign slots[gi] = slot_q;
        end
    endgenerate

    assign count = count_q;
    assign h0    = slots[rd_ptr_q];
    assign h1    = slots[rd_ptr_p1];

endmodule

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: instruction prefetch and alignment stage.
// Fetches aligned 32-bit words into a halfword queue and presents one whole
// instruction per handshake (16-bit compressed, or 32-bit possibly straddling
// a word boundary). A redirect flushes the queue and restarts fetching.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   redirect_valid/redirect_pc    new PC from MEM stage (bit 0 ignored)
//   mem_req_valid/addr/ready      word fetch request (addr[1:0] = 0)
//   mem_resp_valid/data           fetched word, little-endian
//   inst_valid/ready              instruction handshake to decode
//   inst_data                     {h1,h0} or {16'h0,h0} when compressed
//   inst_pc, inst_compressed      PC and size of inst_data
module fetch_align_buffer
    import fetch_align_buffer_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH_HW = DEPTH_HW_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_compressed
);

    localparam int unsigned CW = $clog2(DEPTH_HW) + 1;

    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic            outstanding_q, outstanding_d;
    logic            drop_q, drop_d;       // discard the next response (stale)
    logic            skip_low_q, skip_low_d; // next response: keep upper half only
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic            q_flush;
    logic [1:0]      q_push_cnt;
    logic [15:0]     q_push_hw0, q_push_hw1;
    logic [1:0]      q_pop_cnt;
    logic [CW-1:0]   q_count;
    logic [15:0]     q_h0, q_h1;

    logic            head_compressed;
    logic [XLEN-1:0] redirect_pc_even;

    fab_hw_queue #(
        .DEPTH_HW (DEPTH_HW)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (q_flush),
        .push_cnt (q_push_cnt),
        .push_hw0 (q_push_hw0),
        .push_hw1 (q_push_hw1),
        .pop_cnt  (q_pop_cnt),
        .count    (q_count),
        .h0       (q_h0),
        .h1       (q_h1)
    );

    assign redirect_pc_even = redirect_pc & ~XLEN'(1);

    // Outputs. A request is only raised with room for a whole word; between
    // acceptance and response the queue can only drain, so the response
    // always fits and a raised request stays raised until accepted.
    always_comb begin
        head_compressed = is_compressed(q_h0);
        inst_valid      = !redirect_valid &&
                          (head_compressed ? (q_count != '0) : (q_count >= CW'(2)));
        inst_data       = head_compressed ? {16'h0, q_h0} : {q_h1, q_h0};
        inst_compressed = head_compressed;
        inst_pc         = inst_pc_q;
        mem_req_valid   = !reset && !outstanding_q && !redirect_valid &&
                          (q_count <= CW'(DEPTH_HW - 2));
        mem_req_addr    = fetch_addr_q;
    end

    always_comb begin
        fetch_addr_d  = fetch_addr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        skip_low_d    = skip_low_q;
        inst_pc_d     = inst_pc_q;
        q_flush       = 1'b0;
        q_push_cnt    = 2'd0;
        q_pop_cnt     = 2'd0;
        q_push_hw0    = skip_low_q ? mem_resp_data[31:16] : mem_resp_data[15:0];
        q_push_hw1    = mem_resp_data[31:16];

        if (redirect_valid) begin
            // Any same-cycle response or pop is ignored. A response still in
            // flight must be swallowed when it finally returns.
            q_flush       = 1'b1;
            inst_pc_d     = redirect_pc_even;
            fetch_addr_d  = redirect_pc_even & ~XLEN'(3);
            skip_low_d    = redirect_pc_even[1];
            outstanding_d = outstanding_q && !mem_resp_valid;
            drop_d        = outstanding_q && !mem_resp_valid;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                outstanding_d = 1'b1;
                fetch_addr_d  = fetch_addr_q + XLEN'(4);
            end
            if (mem_resp_valid) begin
                outstanding_d = 1'b0;
                if (drop_q) begin
                    drop_d = 1'b0;
                end else if (skip_low_q) begin
                    q_push_cnt = 2'd1;
                    skip_low_d = 1'b0;
                end else begin
                    q_push_cnt = 2'd2;
                end
            end
            if (inst_valid && inst_ready) begin
                q_pop_cnt = head_compressed ? 2'd1 : 2'd2;
                inst_pc_d = inst_pc_q + (head_compressed ? XLEN'(2) : XLEN'(4));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_addr_q  <= RESET_PC & ~XLEN'(3);
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            skip_low_q    <= RESET_PC[1];
            inst_pc_q     <= RESET_PC & ~XLEN'(1);
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            skip_low_q    <= skip_low_d;
            inst_pc_q     <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_align_buffer.sv
module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;

    fetch_align_buffer #(
        .XLEN     (32),
        .DEPTH_HW (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_compressed (inst_compressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        c;
    } inst_t;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] w0;
        logic [31:0] w1;
        inst_t       e0;
        inst_t       e1;
    } vec_t;

    logic [31:0] mem_arr [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          pend     = 0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    int          lat_cfg   = 0;
    bit          model_on  = 0;
    bit          verbose   = 1;
    logic [31:0] model_pc  = '0;
    bit          last_iv   = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr = '0;
    inst_t       cap_q[$];
    logic [31:0] acc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_arr[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // One clock cycle: memory model drives its response, outputs are sampled
    // at the falling edge, handshakes are recorded, then time moves to just
    // after the next rising edge where the caller sets new inputs.
    task automatic tick();
        inst_t       got;
        logic [15:0] e0, e1;
        logic        ec;
        mem_resp_valid = 1'b0;
        if (pend) begin
            if (pend_wait == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_arr[pend_addr[9:2]];
                pend = 0;
            end else begin
                pend_wait--;
            end
        end
        @(negedge clk);
        cyc++;
        last_iv = inst_valid;
        if (prev_stall && !redirect_valid) begin
            chk("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("req_hold_addr", mem_req_addr, prev_addr);
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_addr  = mem_req_addr;
        if (mem_req_valid && mem_req_ready) begin
            chk("req_align", {30'b0, mem_req_addr[1:0]}, 32'd0);
            pend      = 1;
            pend_addr = mem_req_addr;
            pend_wait = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
            acc_q.push_back(mem_req_addr);
        end
        if (redirect_valid) begin
            chk("iv_in_redirect", {31'b0, inst_valid}, 32'd0);
            model_pc = redirect_pc & ~32'h1;
        end else if (inst_valid && inst_ready) begin
            got = '{inst_data, inst_pc, inst_compressed};
            cap_q.push_back(got);
            if (verbose)
                $display("inst pc=0x%08h data=0x%08h compressed=%0d", inst_pc, inst_data, inst_compressed);
            if (model_on) begin
                e0 = hw_at(model_pc);
                e1 = hw_at(model_pc + 32'd2);
                ec = (e0[1:0] != 2'b11);
                chk("model_pc", inst_pc, model_pc);
                chk("model_data", inst_data, ec ? {16'h0, e0} : {e1, e0});
                chk("model_c", {31'b0, inst_compressed}, {31'b0, ec});
                model_pc = model_pc + (ec ? 32'd2 : 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset the DUT and the memory model together (they share reset).
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        mem_resp_valid = 1'b0;
        pend           = 0;
        prev_stall     = 0;
        @(negedge clk);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        model_pc = '0;
        cap_q.delete();
        acc_q.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem_arr[i] = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{32'h0, 32'h00500093, 32'h00a00113,
                    '{32'h00500093, 32'h0, 1'b0}, '{32'h00a00113, 32'h4, 1'b0}};
        vecs[1] = '{32'h0, 32'h45050505, 32'h00000000,
                    '{32'h00000505, 32'h0, 1'b1}, '{32'h00004505, 32'h2, 1'b1}};
        vecs[2] = '{32'h0, 32'h00930505, 32'h12340050,
                    '{32'h00000505, 32'h0, 1'b1}, '{32'h00500093, 32'h2, 1'b0}};
        vecs[3] = '{32'h6, 32'h0093abcd, 32'h44440050,
                    '{32'h00500093, 32'h6, 1'b0}, '{32'h00004444, 32'ha, 1'b1}};

        // Latency: response in cycle t gives inst_valid in t+1.
        clear_mem();
        mem_arr[0] = 32'h00500093;
        lat_cfg = 0;
        do_reset();
        mem_req_ready = 1'b1;
        tick();
        tick();
        chk("lat_not_yet", {31'b0, last_iv}, 32'd0);
        tick();
        chk("lat_valid", {31'b0, last_iv}, 32'd1);

        // Table-driven streams.
        for (int v = 0; v < 4; v++) begin
            clear_mem();
            mem_arr[vecs[v].start_pc[9:2]]        = vecs[v].w0;
            mem_arr[vecs[v].start_pc[9:2] + 8'd1] = vecs[v].w1;
            do_reset();
            mem_req_ready = 1'b1;
            inst_ready    = 1'b1;
            if (vecs[v].start_pc != 32'h0) begin
                redirect_valid = 1'b1;
                redirect_pc    = vecs[v].start_pc;
                tick();
                redirect_valid = 1'b0;
            end
            for (int k = 0; k < 40 && cap_q.size() < 2; k++) tick();
            chk("vec_count", 32'(cap_q.size()), 32'd2);
            if (cap_q.size() >= 2) begin
                chk("vec_data0", cap_q[0].data, vecs[v].e0.data);
                chk("vec_pc0", cap_q[0].pc, vecs[v].e0.pc);
                chk("vec_c0", {31'b0, cap_q[0].c}, {31'b0, vecs[v].e0.c});
                chk("vec_data1", cap_q[1].data, vecs[v].e1.data);
                chk("vec_pc1", cap_q[1].pc, vecs[v].e1.pc);
                chk("vec_c1", {31'b0, cap_q[1].c}, {31'b0, vecs[v].e1.c});
            end
        end

        // Redirect to 0x102 while a request is outstanding.
        clear_mem();
        mem_arr[0]  = 32'h22222222;
        mem_arr[64] = 32'h4444abcd;
        lat_cfg = 8;
        do_reset();
        mem_req_ready = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        lat_cfg    = 0;
        inst_ready = 1'b1;
        for (int k = 0; k < 40 && cap_q.size() < 1; k++) tick();
        chk("rd_req_count", {31'b0, acc_q.size() >= 2}, 32'd1);
        if (acc_q.size() >= 2) chk("rd_req_addr", acc_q[1], 32'h100);
        chk("rd_inst_seen", {31'b0, cap_q.size() >= 1}, 32'd1);
        if (cap_q.size() >= 1) begin
            chk("rd_inst_data", cap_q[0].data, 32'h00004444);
            chk("rd_inst_pc", cap_q[0].pc, 32'h102);
        end

        // Backpressure: queue fills, requests stop, order preserved on release.
        clear_mem();
        mem_arr[0] = 32'h00500093;
        mem_arr[1] = 32'h45050505;
        mem_arr[2] = 32'h00930505;
        mem_arr[3] = 32'h00a00050;
        mem_arr[4] = 32'h00a00113;
        lat_cfg = 0;
        do_reset();
        model_on      = 1;
        mem_req_ready = 1'b1;
        repeat (10) tick();
        chk("bp_req_stopped", {31'b0, mem_req_valid}, 32'd0);
        chk("bp_accepts", 32'(acc_q.size()), 32'd2);
        chk("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        for (int k = 0; k < 60 && cap_q.size() < 8; k++) tick();
        chk("bp_drained", {31'b0, cap_q.size() >= 8}, 32'd1);
        model_on = 0;

        // Redirect coinciding with a response, then reset mid-fetch.
        clear_mem();
        mem_arr[0]   = 32'h11111111;
        mem_arr[128] = 32'h55550001;
        lat_cfg = 1;
        do_reset();
        mem_req_ready = 1'b1;
        tick();
        tick();
        chk("s6_resp_next", {31'b0, pend && pend_wait == 0}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        lat_cfg    = 0;
        inst_ready = 1'b1;
        for (int k = 0; k < 30 && cap_q.size() < 1; k++) tick();
        chk("s6_inst_seen", {31'b0, cap_q.size() >= 1}, 32'd1);
        if (cap_q.size() >= 1) begin
            chk("s6_inst_data", cap_q[0].data, 32'h00000001);
            chk("s6_inst_pc", cap_q[0].pc, 32'h200);
        end
        lat_cfg = 5;
        tick();
        tick();
        do_reset();
        lat_cfg       = 0;
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        tick();
        chk("s6_req_after_rst", {31'b0, acc_q.size() >= 1}, 32'd1);
        if (acc_q.size() >= 1) chk("s6_req_addr", acc_q[0], 32'h0);
        for (int k = 0; k < 30 && cap_q.size() < 1; k++) tick();
        chk("s6_rst_inst_seen", {31'b0, cap_q.size() >= 1}, 32'd1);
        if (cap_q.size() >= 1) begin
            chk("s6_rst_inst_data", cap_q[0].data, 32'h00001111);
            chk("s6_rst_inst_pc", cap_q[0].pc, 32'h0);
        end

        // Randomized traffic against the reference instruction stream.
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        lat_cfg = -1;
        do_reset();
        model_on = 1;
        verbose  = 0;
        for (int c = 0; c < 4000; c++) begin
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", {31'b0, cap_q.size() > 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
